// File: rtl/life_pkg.sv
// life_pkg: shared types and constants for the Life pass sequencer
package life_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'd0,
        MODE_EVOLVE = 2'd1,
        MODE_CLEAR  = 2'd2,
        MODE_SEED   = 2'd3
    } mode_e;

    localparam int unsigned H_CELLS_DEF = 2200;
    localparam int unsigned V_CELLS_DEF = 1124;
    localparam int unsigned COL_W       = 12;
    localparam int unsigned ROW_W       = 11;
    localparam int unsigned LFSR_W      = 32;

    // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [LFSR_W-1:0] LFSR_POLY = 32'h8020_0003;

endpackage

// File: rtl/life_pass_sequencer_lfsr.sv
// life_lfsr: 32-bit Galois LFSR with enable, exposing its low bit as the random stream
module life_lfsr
    import life_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 32'hACE1_1D5F
) (
    input  logic clock,
    input  logic reset_n,
    input  logic en_i,
    output logic bit_o
);

    logic [LFSR_W-1:0] state_q;

    // Shift right once per enable, folding the polynomial in when a one falls out
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= SEED;
        else if (en_i) state_q <= {1'b0, state_q[LFSR_W-1:1]} ^ (state_q[0] ? LFSR_POLY : '0);
    end

    assign bit_o = state_q[0];

endmodule

// File: rtl/life_pass_sequencer.sv
// life_pass_sequencer: ring pass sequencing, cell coordinates, edge flags and command scheduling
module life_pass_sequencer
    import life_pkg::*;
#(
    parameter int unsigned H_CELLS   = H_CELLS_DEF,
    parameter int unsigned V_CELLS   = V_CELLS_DEF,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_1D5F
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              pix_ce,
    input  logic              cmd_run,
    input  logic              cmd_step,
    input  logic              cmd_clear,
    input  logic              cmd_seed,
    input  logic [3:0]        speed,
    output logic              shift_en,
    output logic [COL_W-1:0]  cell_col,
    output logic [ROW_W-1:0]  cell_row,
    output logic              edge_l,
    output logic              edge_r,
    output logic              edge_t,
    output logic              edge_b,
    output logic [1:0]        mode,
    output logic              seed_bit,
    output logic              pass_start,
    output logic              cmd_ack,
    output logic [31:0]       gen_count
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    mode_e            pass_mode_q, pass_mode_d, next_mode;
    logic             step_q, step_d, clear_q, clear_d, seed_q, seed_d;
    logic             consumed_q, consumed_d;
    logic [3:0]       div_q, div_d;
    logic [31:0]      gen_q, gen_d;
    logic             col_last, row_last, at_first, boundary, any_pending, lfsr_bit;

    logic             shift_en_q, edge_l_q, edge_r_q, edge_t_q, edge_b_q;
    logic             seed_bit_q, pass_start_q, cmd_ack_q;
    logic [COL_W-1:0] cell_col_q;
    logic [ROW_W-1:0] cell_row_q;
    mode_e            mode_q;

    life_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .en_i    (pix_ce),
        .bit_o   (lfsr_bit)
    );

    assign col_last    = col_q == COL_W'(H_CELLS - 1);
    assign row_last    = row_q == ROW_W'(V_CELLS - 1);
    assign at_first    = col_q == '0 && row_q == '0;
    assign boundary    = pix_ce && col_last && row_last;
    assign any_pending = clear_q || seed_q || step_q;
    assign next_mode   = clear_q ? MODE_CLEAR :
                         seed_q  ? MODE_SEED  :
                         step_q  ? MODE_EVOLVE :
                         (cmd_run && div_q >= speed) ? MODE_EVOLVE : MODE_HOLD;

    // Next-state: ring position, pending requests, divider and per-pass mode latched at the boundary
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        pass_mode_d = pass_mode_q;
        consumed_d  = consumed_q;
        gen_d       = gen_q;
        div_d       = div_q;
        if (pix_ce) begin
            col_d = col_last ? '0 : col_q + 1'b1;
            row_d = col_last ? (row_last ? '0 : row_q + 1'b1) : row_q;
        end
        clear_d = cmd_clear | (clear_q & ~boundary);
        seed_d  = cmd_seed  | (seed_q  & ~(boundary & ~clear_q));
        step_d  = cmd_step  | (step_q  & ~(boundary & ~clear_q & ~seed_q));
        if (boundary) begin
            pass_mode_d = next_mode;
            consumed_d  = any_pending;
            gen_d       = gen_q + 32'(pass_mode_q == MODE_EVOLVE);
            div_d       = (any_pending || div_q >= speed) ? '0 : div_q + 1'b1;
        end
        if (!cmd_run) div_d = '0;
    end

    // Sequencer state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col_q       <= '0;
            row_q       <= '0;
            pass_mode_q <= MODE_HOLD;
            step_q      <= 1'b0;
            clear_q     <= 1'b0;
            seed_q      <= 1'b0;
            consumed_q  <= 1'b0;
            div_q       <= '0;
            gen_q       <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pass_mode_q <= pass_mode_d;
            step_q      <= step_d;
            clear_q     <= clear_d;
            seed_q      <= seed_d;
            consumed_q  <= consumed_d;
            div_q       <= div_d;
            gen_q       <= gen_d;
        end
    end

    // Output stage: capture the cell currently at the ring output on each advance, hold otherwise
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_en_q   <= 1'b0;
            cmd_ack_q    <= 1'b0;
            cell_col_q   <= '0;
            cell_row_q   <= '0;
            edge_l_q     <= 1'b0;
            edge_r_q     <= 1'b0;
            edge_t_q     <= 1'b0;
            edge_b_q     <= 1'b0;
            mode_q       <= MODE_HOLD;
            seed_bit_q   <= 1'b0;
            pass_start_q <= 1'b0;
        end else begin
            shift_en_q <= pix_ce;
            cmd_ack_q  <= pix_ce && at_first && consumed_q;
            if (pix_ce) begin
                cell_col_q   <= col_q;
                cell_row_q   <= row_q;
                edge_l_q     <= col_q == '0;
                edge_r_q     <= col_last;
                edge_t_q     <= row_q == '0;
                edge_b_q     <= row_last;
                mode_q       <= pass_mode_q;
                seed_bit_q   <= lfsr_bit;
                pass_start_q <= at_first;
            end
        end
    end

    assign shift_en   = shift_en_q;
    assign cell_col   = cell_col_q;
    assign cell_row   = cell_row_q;
    assign edge_l     = edge_l_q;
    assign edge_r     = edge_r_q;
    assign edge_t     = edge_t_q;
    assign edge_b     = edge_b_q;
    assign mode       = mode_q;
    assign seed_bit   = seed_bit_q;
    assign pass_start = pass_start_q;
    assign cmd_ack    = cmd_ack_q;
    assign gen_count  = gen_q;

endmodule

// File: tb/tb_life_pass_sequencer.sv
// tb_life_pass_sequencer: directed self-checking bench on a small 8x4 board
module tb_life_pass_sequencer;
    import life_pkg::*;

    localparam int H = 8;
    localparam int V = 4;

    logic        clock = 1'b0, reset_n = 1'b0, pix_ce = 1'b0;
    logic        cmd_run = 1'b0, cmd_step = 1'b0, cmd_clear = 1'b0, cmd_seed = 1'b0;
    logic [3:0]  speed = 4'd0;
    logic        shift_en, edge_l, edge_r, edge_t, edge_b, seed_bit, pass_start, cmd_ack;
    logic [11:0] cell_col;
    logic [10:0] cell_row;
    logic [1:0]  mode;
    logic [31:0] gen_count;

    int checks = 0, errors = 0, acks = 0, a0 = 0, n = 0, k = 0;
    bit stable;

    life_pass_sequencer #(.H_CELLS(H), .V_CELLS(V)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .pix_ce     (pix_ce),
        .cmd_run    (cmd_run),
        .cmd_step   (cmd_step),
        .cmd_clear  (cmd_clear),
        .cmd_seed   (cmd_seed),
        .speed      (speed),
        .shift_en   (shift_en),
        .cell_col   (cell_col),
        .cell_row   (cell_row),
        .edge_l     (edge_l),
        .edge_r     (edge_r),
        .edge_t     (edge_t),
        .edge_b     (edge_b),
        .mode       (mode),
        .seed_bit   (seed_bit),
        .pass_start (pass_start),
        .cmd_ack    (cmd_ack),
        .gen_count  (gen_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (cmd_ack === 1'b1) acks++;
    endtask

    task automatic goto_start(output int cnt);
        logic [1:0] m0;
        m0 = mode;
        stable = 1'b1;
        cnt = 0;
        do begin
            tick();
            cnt++;
            if (shift_en === 1'b1 && pass_start !== 1'b1 && mode !== m0) stable = 1'b0;
        end while (!(shift_en === 1'b1 && pass_start === 1'b1) && cnt < 500);
        checks++;
        assert (cnt < 500) else begin
            errors++;
            $error("FAIL pass_timeout: observed %0d cycles expected <500", cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pix_ce = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_shift_en", shift_en, 0);
        chk("rst_col", cell_col, 0);
        chk("rst_row", cell_row, 0);
        chk("rst_edges", {edge_l, edge_r, edge_t, edge_b}, 0);
        chk("rst_mode", mode, MODE_HOLD);
        chk("rst_pass_start", pass_start, 0);
        chk("rst_ack", cmd_ack, 0);
        chk("rst_gen", gen_count, 0);
        reset_n = 1'b1;
        chk("rel_shift_en", shift_en, 0);
        tick();
        chk("first_shift_en", shift_en, 1);
        chk("first_pass_start", pass_start, 1);
        chk("first_col", cell_col, 0);
        chk("first_row", cell_row, 0);
        chk("first_edges", {edge_l, edge_r, edge_t, edge_b}, 4'b1010);
        chk("first_mode", mode, MODE_HOLD);
        chk("seed_bit0", seed_bit, 1);
        tick();
        chk("col1", cell_col, 1);
        chk("pass_start_drop", pass_start, 0);
        chk("seed_bit1", seed_bit, 0);
        tick();
        chk("seed_bit2", seed_bit, 0);
        repeat (5) tick();
        chk("col_last", cell_col, H - 1);
        chk("edges_right", {edge_l, edge_r, edge_t, edge_b}, 4'b0110);
        tick();
        chk("wrap_col", cell_col, 0);
        chk("wrap_row", cell_row, 1);
        chk("edges_row1", {edge_l, edge_r, edge_t, edge_b}, 4'b1000);
        goto_start(n);
        chk("pass_len", n + 8, H * V);
        chk("hold_stable", stable, 1);
        chk("pass2_mode", mode, MODE_HOLD);

        repeat (5) tick();
        cmd_step = 1'b1;
        tick();
        cmd_step = 1'b0;
        chk("step_mid_mode", mode, MODE_HOLD);
        a0 = acks;
        goto_start(n);
        chk("step_wait_stable", stable, 1);
        chk("step_mode", mode, MODE_EVOLVE);
        chk("step_ack", cmd_ack, 1);
        tick();
        chk("step_ack_pulse", cmd_ack, 0);
        goto_start(n);
        chk("after_step_mode", mode, MODE_HOLD);
        chk("after_step_ack", cmd_ack, 0);
        chk("after_step_gen", gen_count, 1);
        chk("step_ack_count", acks - a0, 1);

        repeat (3) tick();
        cmd_clear = 1'b1;
        cmd_seed  = 1'b1;
        tick();
        cmd_clear = 1'b0;
        cmd_seed  = 1'b0;
        a0 = acks;
        goto_start(n);
        chk("clear_mode", mode, MODE_CLEAR);
        chk("clear_ack", cmd_ack, 1);
        goto_start(n);
        chk("seed_mode", mode, MODE_SEED);
        chk("seed_ack", cmd_ack, 1);
        goto_start(n);
        chk("cs_after_mode", mode, MODE_HOLD);
        chk("cs_after_ack", cmd_ack, 0);
        chk("cs_ack_count", acks - a0, 2);
        chk("cs_gen", gen_count, 1);

        cmd_run = 1'b1;
        speed   = 4'd2;
        a0 = acks;
        for (int p = 1; p <= 9; p++) begin
            goto_start(n);
            chk($sformatf("run_pass%0d", p), mode, (p % 3 == 0) ? MODE_EVOLVE : MODE_HOLD);
        end
        chk("run_gen", gen_count, 3);
        cmd_run = 1'b0;
        goto_start(n);
        chk("run_off_mode", mode, MODE_HOLD);
        chk("run_off_gen", gen_count, 4);
        chk("run_no_ack", acks - a0, 0);

        repeat (3) tick();
        cmd_step = 1'b1;
        tick();
        cmd_step = 1'b0;
        k = 0;
        while (!(cell_col == 12'(H - 2) && cell_row == 11'(V - 1)) && k < 100) begin
            tick();
            k++;
        end
        cmd_step = 1'b1;
        tick();
        cmd_step = 1'b0;
        chk("bnd_col", cell_col, H - 1);
        chk("bnd_row", cell_row, V - 1);
        a0 = acks;
        tick();
        chk("dbl_start", pass_start, 1);
        chk("dbl_mode1", mode, MODE_EVOLVE);
        chk("dbl_ack1", cmd_ack, 1);
        goto_start(n);
        chk("dbl_mode2", mode, MODE_EVOLVE);
        chk("dbl_ack2", cmd_ack, 1);
        goto_start(n);
        chk("dbl_after_mode", mode, MODE_HOLD);
        chk("dbl_ack_count", acks - a0, 2);
        chk("dbl_gen", gen_count, 6);

        k = 0;
        while (cell_row != 11'd2 && k < 300) begin
            pix_ce = (k % 3 == 0);
            tick();
            k++;
        end
        chk("gap_reach_row", cell_row, 2);
        pix_ce = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_shift_en", shift_en, 0);
        chk("arst_col", cell_col, 0);
        chk("arst_row", cell_row, 0);
        chk("arst_gen", gen_count, 0);
        chk("arst_mode", mode, MODE_HOLD);
        chk("arst_edges", {edge_l, edge_r, edge_t, edge_b}, 0);
        #2 reset_n = 1'b1;
        tick();
        chk("gap_idle_shift", shift_en, 0);
        pix_ce = 1'b1;
        tick();
        pix_ce = 1'b0;
        chk("gap_shift1", shift_en, 1);
        chk("gap_start", pass_start, 1);
        chk("gap_col0", cell_col, 0);
        chk("gap_row0", cell_row, 0);
        chk("gap_seed0", seed_bit, 1);
        tick();
        chk("gap_shift_off", shift_en, 0);
        chk("gap_start_hold", pass_start, 1);
        chk("gap_col_hold", cell_col, 0);
        tick();
        chk("gap_shift_off2", shift_en, 0);
        pix_ce = 1'b1;
        tick();
        chk("gap_shift2", shift_en, 1);
        chk("gap_col1", cell_col, 1);
        chk("gap_start_drop", pass_start, 0);
        chk("gap_seed1", seed_bit, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/life_pass_sequencer.md
Name: life_pass_sequencer

Overview:
- Sequences the 1-bit cell ring store and the row tap lines of the Life engine. One full ring revolution is one "pass".
- Per pass, it selects what is written back into the ring: recirculate, evolve, clear or random seed.
- Advances cell coordinates, flags board edges for the rule logic, and schedules run/step/clear/seed commands onto pass boundaries.
- Sits between the host command registers and the ring/rule datapath.

Parameters:
- H_CELLS, 2200, cells per row (ring row length).
- V_CELLS, 1124, rows per pass; H_CELLS*V_CELLS equals ring depth.
- LFSR_SEED, 32'hACE1_1D5F, reset value of the seed LFSR; must be nonzero.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pix_ce  in  1  cell-rate clock enable; one ring advance per asserted cycle
- cmd_run  in  1  level; 1 = free-running evolution
- cmd_step  in  1  pulse; request one evolve pass
- cmd_clear  in  1  pulse; request one clear pass
- cmd_seed  in  1  pulse; request one random-seed pass
- speed  in  4  free-run divider; evolve one pass in every speed+1
- shift_en  out  1  ring/row-tap enable
- cell_col  out  12  column of the cell at ring output, 0..H_CELLS-1
- cell_row  out  11  row of the cell at ring output, 0..V_CELLS-1
- edge_l, edge_r, edge_t, edge_b  out  1 each  cell lies on the left/right/top/bottom board edge
- mode  out  2  write source: 0 HOLD, 1 EVOLVE, 2 CLEAR, 3 SEED
- seed_bit  out  1  LFSR bit for the SEED write source
- pass_start  out  1  one-cycle pulse coincident with the first cell of a pass
- cmd_ack  out  1  one-cycle pulse when a pending step/clear/seed is consumed
- gen_count  out  32  completed EVOLVE passes, wraps at 2^32

Behaviour:
- Reset values: shift_en 0, cell_col 0, cell_row 0, all edge flags 0, mode HOLD, pass_start 0, cmd_ack 0, gen_count 0, LFSR = LFSR_SEED, all pending flags 0, divider 0.
- Reset is asynchronous and may arrive mid-pass. The next pass after release starts at (0,0) in HOLD. Ring contents are not touched by this block.
- shift_en is pix_ce registered (latency 1). cell_col, cell_row, edge flags, mode, seed_bit and pass_start are registered and valid exactly in cycles where shift_en=1. They hold their values otherwise.
- Counters advance only on pix_ce:
  - cell_col increments and wraps H_CELLS-1 -> 0.
  - On that wrap, cell_row increments and wraps V_CELLS-1 -> 0.
- Edge flags: edge_l = col==0, edge_r = col==H_CELLS-1, edge_t = row==0, edge_b = row==V_CELLS-1.
- Pending flags (step, clear, seed): set by their input pulse, cleared on consumption.
  - A pulse in the same cycle as consumption leaves the flag set, so the request is served on the following pass.
  - Repeated pulses while pending collapse to one request.
- Pass boundary = pix_ce while col==H_CELLS-1 and row==V_CELLS-1. At each boundary the next-pass mode is chosen by strict priority:
  - clear pending -> CLEAR
  - else seed pending -> SEED
  - else step pending -> EVOLVE
  - else cmd_run and divider==speed -> EVOLVE
  - else HOLD
- The chosen mode is held for the whole next pass. Commands arriving mid-pass never change the current mode.
- Consuming a pending flag pulses cmd_ack in the cycle that pass_start is asserted. Free-run EVOLVE does not ack.
- Divider:
  - counts boundaries while cmd_run=1 and resets to 0 when it equals speed.
  - is forced to 0 whenever cmd_run=0, and on any CLEAR/SEED/step pass.
  - A lower speed written mid-count takes effect at the next compare: divider>speed counts as equal.
- gen_count increments at the boundary that ends an EVOLVE pass.
- LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1. Advances on every pix_ce in any mode; seed_bit = LFSR[0].

Decomposition:
- Package life_pkg:
  - mode enum (HOLD/EVOLVE/CLEAR/SEED)
  - H_CELLS/V_CELLS defaults
  - coordinate width constants
  - LFSR polynomial constant
- One sub-module, life_lfsr: 32-bit Galois LFSR with enable and seed parameter.

Test Plan:
- Reset release, pix_ce=1 continuous -> shift_en rises 1 cycle later; pass_start at (0,0); col wraps 2199->0 with row+1; next pass_start after exactly 2472800 advances; mode HOLD throughout.
- cmd_step pulse mid-pass -> mode stays HOLD to the boundary; next pass EVOLVE with cmd_ack at its pass_start; following pass HOLD; gen_count=1 after it ends.
- cmd_clear and cmd_seed pulsed in the same cycle -> CLEAR pass, then SEED pass, each acked once, then HOLD; gen_count unchanged.
- cmd_run=1, speed=2 for 9 passes -> EVOLVE on passes 3, 6, 9 only; gen_count=3; drop cmd_run -> HOLD from the next pass.
- cmd_step pulsed exactly on the consuming boundary cycle of an earlier step -> two consecutive EVOLVE passes, two acks.
- reset_n asserted at row 500 with pix_ce gapped (1 of 3 cycles) -> outputs clear asynchronously; after release, counters restart at (0,0); shift_en follows the gapped pix_ce with 1-cycle latency.
